// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: debounces entry/exit lane sensors, tracks committed
// occupancy and hands single-cycle admit/release requests to the door stage.
module parking_gate_ctrl #(
  parameter int CAPACITY        = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BUSY_TIMEOUT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  input  logic       door_busy,
  output logic       car_in,
  output logic       car_out,
  output logic [3:0] occupancy,
  output logic       full,
  output logic       empty,
  output logic       entry_rejected,
  output logic       exit_rejected,
  output logic [1:0] dbg_state
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]    CAP     = 4'(CAPACITY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  // Lane index 0 = entry, 1 = exit.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    filt_q, filt_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [1:0]    rise;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          entry_pend_q, entry_pend_d;
  logic          exit_pend_q, exit_pend_d;
  logic [3:0]    occ_q, occ_d;
  logic          car_in_q, car_in_d;
  logic          car_out_q, car_out_d;
  logic          erej_q, erej_d;
  logic          xrej_q, xrej_d;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive
  // mismatching cycles; the event fires on the cycle the filter flips to 1.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      rise[i]   = 1'b0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          filt_d[i] = sync2_q[i];
          rise[i]   = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    entry_pend_d = entry_pend_q;
    exit_pend_d  = exit_pend_q;
    occ_d        = occ_q;
    car_in_d     = 1'b0;
    car_out_d    = 1'b0;
    erej_d       = 1'b0;
    xrej_d       = 1'b0;

    // Acceptance looks at occupancy as registered, before any issue this cycle.
    if (rise[0]) begin
      if (!entry_pend_q && (occ_q < CAP)) entry_pend_d = 1'b1;
      else                                erej_d       = 1'b1;
    end
    if (rise[1]) begin
      if (!exit_pend_q && (occ_q != 4'd0)) exit_pend_d = 1'b1;
      else                                 xrej_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!door_busy) begin
          if (exit_pend_q) begin
            car_out_d   = 1'b1;
            exit_pend_d = 1'b0;
            if (occ_q != 4'd0) occ_d = occ_q - 4'd1;
            tmr_d       = '0;
            state_d     = WAIT_HI;
          end else if (entry_pend_q) begin
            car_in_d     = 1'b1;
            entry_pend_d = 1'b0;
            if (occ_q < CAP) occ_d = occ_q + 4'd1;
            tmr_d        = '0;
            state_d      = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        if (door_busy)              state_d = WAIT_LO;
        else if (tmr_q == TO_LAST)  state_d = IDLE;
        else                        tmr_d   = tmr_q + 1'b1;
      end
      WAIT_LO: begin
        if (!door_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      filt_q       <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      state_q      <= IDLE;
      tmr_q        <= '0;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      occ_q        <= 4'd0;
      car_in_q     <= 1'b0;
      car_out_q    <= 1'b0;
      erej_q       <= 1'b0;
      xrej_q       <= 1'b0;
    end else begin
      sync1_q      <= {exit_sensor, entry_sensor};
      sync2_q      <= sync1_q;
      filt_q       <= filt_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      occ_q        <= occ_d;
      car_in_q     <= car_in_d;
      car_out_q    <= car_out_d;
      erej_q       <= erej_d;
      xrej_q       <= xrej_d;
    end
  end

  assign car_in         = car_in_q;
  assign car_out        = car_out_q;
  assign occupancy      = occ_q;
  assign full           = (occ_q == CAP);
  assign empty          = (occ_q == 4'd0);
  assign entry_rejected = erej_q;
  assign exit_rejected  = xrej_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: stimulus pushes expected pulse words,
// an independent monitor pops and compares every pulse the DUT presents.
module tb_parking_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry_sensor, exit_sensor, door_busy;
  logic       car_in, car_out, full, empty, entry_rejected, exit_rejected;
  logic [3:0] occupancy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  bit prev_issue = 1'b0;

  parking_gate_ctrl #(.CAPACITY(8), .DEBOUNCE_CYCLES(16), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .door_busy(door_busy), .car_in(car_in), .car_out(car_out), .occupancy(occupancy),
    .full(full), .empty(empty), .entry_rejected(entry_rejected),
    .exit_rejected(exit_rejected), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Pulse word layout: {car_in, car_out, entry_rejected, exit_rejected, occupancy}
  function automatic logic [7:0] ev(input logic ci, input logic co, input logic er,
                                    input logic xr, input int occ);
    return {ci, co, er, xr, 4'(occ)};
  endfunction

  always @(negedge clk) begin
    logic [7:0] got, exp;
    if (!rst && (car_in || car_out || entry_rejected || exit_rejected)) begin
      got = {car_in, car_out, entry_rejected, exit_rejected, occupancy};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected got=%h expected=none t=%0t", got, $time);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL pulse_word got=%h expected=%h t=%0t", got, exp, $time);
        end
      end
      if (car_in || car_out) begin
        checks++;
        if (prev_issue) begin
          errors++;
          $display("FAIL issue_back_to_back got=1 expected=0 t=%0t", $time);
        end
      end
    end
    prev_issue = !rst && (car_in || car_out);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    door_busy = 1'b0;
    entry_sensor = 1'b0;
    exit_sensor = 1'b0;
    cycles(3);
    rst = 1'b0;
  endtask

  task automatic entry_car(input int hi);
    entry_sensor = 1'b1;
    cycles(hi);
    entry_sensor = 1'b0;
    cycles(24);
  endtask

  task automatic exit_car(input int hi);
    exit_sensor = 1'b1;
    cycles(hi);
    exit_sensor = 1'b0;
    cycles(24);
  endtask

  task automatic wait_issue(input string name, input bit want_out, input int budget,
                            output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (want_out ? car_out : car_in) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s got=timeout expected=pulse t=%0t", name, $time);
    end
  endtask

  task automatic sb_drained(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    bit seen;
    int gap;

    // Reset state
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_state", int'(dbg_state), 0);
    chk("rst_car_in", int'(car_in), 0);
    cycles(1);
    rst = 1'b0;

    // Exit when empty is rejected
    exp_q.push_back(ev(0, 0, 0, 1, 0));
    exit_car(20);
    @(negedge clk);
    chk("exit_rej_occupancy", int'(occupancy), 0);
    sb_drained("drain_exit_rej");

    // Short glitch never passes the filter
    entry_car(10);
    @(negedge clk);
    chk("glitch_occupancy", int'(occupancy), 0);
    chk("glitch_empty", int'(empty), 1);
    sb_drained("drain_glitch");

    // First admitted car
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    entry_car(20);
    @(negedge clk);
    chk("first_occupancy", int'(occupancy), 1);
    chk("first_empty", int'(empty), 0);
    chk("first_state_idle", int'(dbg_state), 0);

    // Fill to capacity, then one more is rejected
    for (int k = 2; k <= 8; k++) begin
      exp_q.push_back(ev(1, 0, 0, 0, k));
      entry_car(20);
    end
    @(negedge clk);
    chk("fill_occupancy", int'(occupancy), 8);
    chk("fill_full", int'(full), 1);
    exp_q.push_back(ev(0, 0, 1, 0, 8));
    entry_car(20);
    @(negedge clk);
    chk("over_occupancy", int'(occupancy), 8);
    chk("over_full", int'(full), 1);
    sb_drained("drain_fill");

    // Simultaneous entry and exit at occupancy 3: exit first, door busy 5 cycles
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(ev(1, 0, 0, 0, k));
      entry_car(20);
    end
    exp_q.push_back(ev(0, 1, 0, 0, 2));
    exp_q.push_back(ev(1, 0, 0, 0, 3));
    fork
      begin
        entry_sensor = 1'b1;
        exit_sensor = 1'b1;
        cycles(20);
        entry_sensor = 1'b0;
        exit_sensor = 1'b0;
        cycles(24);
      end
      begin
        wait_issue("both_car_out", 1'b1, 60, seen);
        if (seen) begin
          cycles(1);
          door_busy = 1'b1;
          cycles(4);
          @(negedge clk);
          chk("both_wait_lo", int'(dbg_state), 2);
          chk("both_no_car_in", int'(car_in), 0);
          cycles(1);
          door_busy = 1'b0;
        end
      end
    join
    cycles(10);
    @(negedge clk);
    chk("both_occupancy", int'(occupancy), 3);
    sb_drained("drain_both");

    // door_busy never rises: WAIT_HI times out, then the pending exit issues
    do_reset();
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    exp_q.push_back(ev(0, 1, 0, 0, 0));
    fork
      entry_car(20);
      begin
        cycles(3);
        exit_car(20);
      end
      begin
        wait_issue("timeout_car_in", 1'b0, 60, seen);
        gap = 0;
        if (seen) begin
          do begin
            @(negedge clk);
            gap++;
            if (gap == 4) chk("timeout_back_idle", int'(dbg_state), 0);
          end while (!car_out && gap < 20);
          chk("timeout_gap", gap, 5);
        end
      end
    join
    @(negedge clk);
    chk("timeout_occupancy", int'(occupancy), 0);
    sb_drained("drain_timeout");

    // Reset while in WAIT_LO with a new entry pending
    do_reset();
    exp_q.push_back(ev(1, 0, 0, 0, 1));
    fork
      entry_car(20);
      begin
        wait_issue("rst_case_car_in", 1'b0, 60, seen);
        cycles(1);
        door_busy = 1'b1;
      end
    join
    entry_car(20);
    @(negedge clk);
    chk("rst_case_wait_lo", int'(dbg_state), 2);
    chk("rst_case_occ_before", int'(occupancy), 1);
    cycles(1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    door_busy = 1'b0;
    @(negedge clk);
    chk("rst_case_occupancy", int'(occupancy), 0);
    chk("rst_case_empty", int'(empty), 1);
    chk("rst_case_state", int'(dbg_state), 0);
    cycles(30);
    @(negedge clk);
    chk("rst_case_still_zero", int'(occupancy), 0);
    sb_drained("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 8, max cars admitted (1..15).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles needed to accept a sensor level change (>=2).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 4, max cycles to wait for door_busy to rise after an issued pulse.
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port entry_sensor  input  1  raw asynchronous entry-lane sensor, 1 = car present.
REQ-007 SHALL have port exit_sensor  input  1  raw asynchronous exit-lane sensor, 1 = car present.
REQ-008 SHALL have port door_busy  input  1  downstream door stage is sequencing, 1 = busy.
REQ-009 SHALL have port car_in  output  1  single-cycle admit request to the door stage.
REQ-010 SHALL have port car_out  output  1  single-cycle release request to the door stage.
REQ-011 SHALL have port occupancy  output  4  committed car count, 0..CAPACITY.
REQ-012 SHALL have port full  output  1  occupancy == CAPACITY.
REQ-013 SHALL have port empty  output  1  occupancy == 0.
REQ-014 SHALL have port entry_rejected  output  1  single-cycle pulse, entry event not accepted.
REQ-015 SHALL have port exit_rejected  output  1  single-cycle pulse, exit event not accepted.

Function
REQ-016 SHALL pass each sensor through a 2-flop synchronizer before any other use.
REQ-017 SHALL change a sensor's filtered level only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts that sensor's counter.
REQ-018 SHALL generate an entry/exit event on the cycle the corresponding filtered level rises 0->1; falling edges generate nothing.
REQ-019 SHALL accept an entry event only if entry_pend == 0 and occupancy < CAPACITY (setting entry_pend), else pulse entry_rejected the next cycle.
REQ-020 SHALL accept an exit event only if exit_pend == 0 and occupancy > 0 (setting exit_pend), else pulse exit_rejected the next cycle.
REQ-021 SHALL implement issue FSM states IDLE, WAIT_HI, WAIT_LO.
REQ-022 IDLE SHALL, when door_busy == 0 and exit_pend == 1, assert car_out one cycle, clear exit_pend, decrement occupancy, go WAIT_HI.
REQ-023 IDLE SHALL, when door_busy == 0, exit_pend == 0, entry_pend == 1, assert car_in one cycle, clear entry_pend, increment occupancy, go WAIT_HI.
REQ-024 SHALL give exit priority over entry when both are pending.
REQ-025 WAIT_HI SHALL go WAIT_LO when door_busy == 1, or IDLE after BUSY_TIMEOUT cycles without door_busy.
REQ-026 WAIT_LO SHALL go IDLE on the first cycle door_busy == 0.
REQ-027 SHALL never assert car_in and car_out in the same cycle, and never in consecutive cycles.
REQ-028 SHALL update occupancy in the same edge that registers the pulse; full/empty are combinational from registered occupancy.
REQ-029 SHALL evaluate acceptance against occupancy before that cycle's update when an event and an issue coincide.
REQ-030 SHALL never wrap occupancy below 0 or above CAPACITY.

Reset
REQ-031 SHALL on rst = 1 at a clk edge clear occupancy, pending flags, debounce counters, filtered levels, synchronizers, car_in, car_out, entry_rejected, exit_rejected, and go IDLE; full = 0, empty = 1.
REQ-032 SHALL discard any pending or in-flight request when rst asserts mid-operation; no pulse in the cycle after reset release.

Verification
REQ-033 entry_sensor high 20 cycles, door_busy low -> one car_in pulse, occupancy 0->1, empty falls.
REQ-034 entry_sensor glitch high 10 cycles -> no car_in, no rejection, occupancy stays 0.
REQ-035 occupancy = 8, new entry event -> entry_rejected pulse, no car_in, full stays 1.
REQ-036 entry and exit events same cycle, occupancy = 3, door_busy low -> car_out first, door_busy 1 for 5 cycles then 0, then car_in; final occupancy 3.
REQ-037 car_in issued, door_busy never rises -> FSM returns IDLE after 4 cycles; next pending request issues.
REQ-038 rst asserted in WAIT_LO with entry pending -> occupancy 0, no pulse after release.
